icmp_rx: RTL and testbench



---
 rtl/icmp_rx.sv | 237 +++++++++++++++++++++++
 tb/tb_icmp_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icmp_rx.sv
// icmp_rx: GMII receive-side ICMP echo-request parser.
// Filters IPv4 ICMP echo requests addressed to the board and latches the
// requester's MAC, IP, identifier and sequence number for the reply path.
// Optional feature macro: ICMP_RX_CRC_CHECK_EN builds an FCS check; without
// it the last four bytes of the frame are ignored.

`ifdef ICMP_RX_CRC_CHECK_EN
// Byte-wide reflected CRC-32 (poly 0xEDB88320). crc_out is the FCS value
// as transmitted: complemented, low byte first on the wire.
module crc32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_load,
  input  logic [31:0] pre_crc,
  input  logic [7:0]  data_in,
  input  logic        crc_en,
  output logic [31:0] crc_out
);
  logic [31:0] crc_q;
  logic [31:0] crc_next;

  // Next CRC after folding in one byte, LSB first.
  always_comb begin
    crc_next = crc_q ^ {24'h0, data_in};
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ 32'hEDB8_8320) : (crc_next >> 1);
    end
  end

  // Running CRC register: seeded on load, advanced on each enabled byte.
  always_ff @(posedge clk) begin
    if (rst)           crc_q <= 32'hFFFF_FFFF;
    else if (crc_load) crc_q <= pre_crc;
    else if (crc_en)   crc_q <= crc_next;
  end

  assign crc_out = ~crc_q;
endmodule
`endif

module icmp_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter int          MAX_FRAME = 1522
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gmii_eth_rxd,
  input  logic        gmii_eth_rxdv,
  output logic [47:0] pc_mac,
  output logic [31:0] pc_ip,
  output logic [15:0] identify,
  output logic [15:0] seq_num,       // ICMP sequence number ("sequence" is a reserved word)
  output logic        icmp_rx_done,
  output logic        icmp_rx_err
);

  typedef enum logic [2:0] {
    IDLE, PRE, ETH_HDR, IP_HDR, ICMP_HDR, PAYLOAD, DROP
  } state_t;

  localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME);
  localparam logic [10:0] MIN_CNT = 11'd46;

  state_t      state;
  logic        prev_dv;
  logic [2:0]  pre_cnt;
  logic [10:0] byte_cnt;     // bytes accepted since SFD; also the header offset
  logic [47:0] sh_mac;
  logic [31:0] sh_ip;
  logic [15:0] sh_id;
  logic [15:0] sh_seq;
  logic        chk_byte;
  logic [7:0]  exp_byte;
  logic        fcs_ok;

  // Filter table: which header offsets must match and the byte they must equal.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // latch behind.
  always_comb begin
    chk_byte = 1'b1;
    exp_byte = 8'h00;
    case (byte_cnt)
      11'd0:   exp_byte = BOARD_MAC[47:40];
      11'd1:   exp_byte = BOARD_MAC[39:32];
      11'd2:   exp_byte = BOARD_MAC[31:24];
      11'd3:   exp_byte = BOARD_MAC[23:16];
      11'd4:   exp_byte = BOARD_MAC[15:8];
      11'd5:   exp_byte = BOARD_MAC[7:0];
      11'd12:  exp_byte = 8'h08;               // EtherType IPv4
      11'd13:  exp_byte = 8'h00;
      11'd14:  exp_byte = 8'h45;               // version 4, IHL 5
      11'd23:  exp_byte = 8'h01;               // protocol ICMP
      11'd30:  exp_byte = BOARD_IP[31:24];
      11'd31:  exp_byte = BOARD_IP[23:16];
      11'd32:  exp_byte = BOARD_IP[15:8];
      11'd33:  exp_byte = BOARD_IP[7:0];
      11'd34:  exp_byte = 8'h08;               // echo request
      11'd35:  exp_byte = 8'h00;               // code 0
      default: chk_byte = 1'b0;
    endcase
  end

`ifdef ICMP_RX_CRC_CHECK_EN
  // The last four bytes are the FCS, so bytes reach the CRC only once four
  // newer bytes have arrived behind them.
  logic [3:0][7:0] fcs_dly;
  logic [2:0]      dly_cnt;
  logic            crc_load;
  logic            byte_take;
  logic            crc_en;
  logic [31:0]     crc_out;

  assign crc_load  = (state == PRE) && gmii_eth_rxdv && (gmii_eth_rxd == 8'hD5);
  assign byte_take = gmii_eth_rxdv && (state inside {ETH_HDR, IP_HDR, ICMP_HDR, PAYLOAD});
  assign crc_en    = byte_take && (dly_cnt == 3'd4);

  // Four-byte delay line in front of the CRC, restarted at SFD.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcs_dly <= '0;
      dly_cnt <= 3'd0;
    end else if (crc_load) begin
      dly_cnt <= 3'd0;
    end else if (byte_take) begin
      fcs_dly <= {fcs_dly[2:0], gmii_eth_rxd};
      if (dly_cnt != 3'd4) dly_cnt <= dly_cnt + 3'd1;
    end
  end

  crc32 u_crc32 (
    .clk      (clk),
    .rst      (rst),
    .crc_load (crc_load),
    .pre_crc  (32'hFFFF_FFFF),
    .data_in  (fcs_dly[3]),
    .crc_en   (crc_en),
    .crc_out  (crc_out)
  );

  // fcs_dly[3] holds the first FCS byte to arrive, which carries crc_out[7:0].
  assign fcs_ok = (crc_out == {fcs_dly[0], fcs_dly[1], fcs_dly[2], fcs_dly[3]});
`else
  assign fcs_ok = 1'b1;
`endif

  // Frame parser: preamble, header filtering, field capture and result pulses.
  // NOTE: all state here uses <= so every read sees the pre-edge value,
  // regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      // Seeding with the live rxdv means a frame already running at reset
      // release never looks like a rising edge.
      prev_dv      <= gmii_eth_rxdv;
      pre_cnt      <= 3'd0;
      byte_cnt     <= 11'd0;
      sh_mac       <= '0;
      sh_ip        <= '0;
      sh_id        <= '0;
      sh_seq       <= '0;
      pc_mac       <= '0;
      pc_ip        <= '0;
      identify     <= '0;
      seq_num      <= '0;
      icmp_rx_done <= 1'b0;
      icmp_rx_err  <= 1'b0;
    end else begin
      prev_dv      <= gmii_eth_rxdv;
      icmp_rx_done <= 1'b0;
      icmp_rx_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (gmii_eth_rxdv && !prev_dv) begin
            if (gmii_eth_rxd == 8'h55) begin
              state   <= PRE;
              pre_cnt <= 3'd1;
            end else begin
              state <= DROP;
            end
          end
        end

        PRE: begin
          if (!gmii_eth_rxdv) begin
            state <= IDLE;
          end else if (gmii_eth_rxd == 8'h55) begin
            if (pre_cnt == 3'd7) state <= DROP;
            else                 pre_cnt <= pre_cnt + 3'd1;
          end else if (gmii_eth_rxd == 8'hD5) begin
            state    <= ETH_HDR;
            byte_cnt <= 11'd0;
          end else begin
            state <= DROP;
          end
        end

        ETH_HDR, IP_HDR, ICMP_HDR, PAYLOAD: begin
          if (!gmii_eth_rxdv) begin
            state <= IDLE;
            if ((state == PAYLOAD) && (byte_cnt >= MIN_CNT) && fcs_ok) begin
              icmp_rx_done <= 1'b1;
              pc_mac       <= sh_mac;
              pc_ip        <= sh_ip;
              identify     <= sh_id;
              seq_num      <= sh_seq;
            end else begin
              icmp_rx_err <= 1'b1;
            end
          end else if (byte_cnt == MAX_CNT) begin
            icmp_rx_err <= 1'b1;
            state       <= DROP;
          end else if (chk_byte && (gmii_eth_rxd != exp_byte)) begin
            state <= DROP;
          end else begin
            byte_cnt <= byte_cnt + 11'd1;
            if (byte_cnt >= 11'd6  && byte_cnt <= 11'd11) sh_mac <= {sh_mac[39:0], gmii_eth_rxd};
            if (byte_cnt >= 11'd26 && byte_cnt <= 11'd29) sh_ip  <= {sh_ip[23:0],  gmii_eth_rxd};
            if (byte_cnt >= 11'd38 && byte_cnt <= 11'd39) sh_id  <= {sh_id[7:0],   gmii_eth_rxd};
            if (byte_cnt >= 11'd40 && byte_cnt <= 11'd41) sh_seq <= {sh_seq[7:0],  gmii_eth_rxd};
            if (byte_cnt == 11'd13) state <= IP_HDR;
            if (byte_cnt == 11'd33) state <= ICMP_HDR;
            if (byte_cnt == 11'd41) state <= PAYLOAD;
          end
        end

        DROP: begin
          if (!gmii_eth_rxdv) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icmp_rx.sv
// tb_icmp_rx: table-driven frame vectors for icmp_rx plus hand-written
// sequences for reset mid-frame and the oversize-frame limit.
module tb_icmp_rx;

`ifdef ICMP_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    int          pre_len;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [7:0]  ver_ihl;
    logic [7:0]  proto;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  icmp_type;
    logic [15:0] id;
    logic [15:0] seq;
    int          pay_len;
    bit          fcs_flip;
    int          trunc;      // post-SFD bytes to send, 0 = whole frame
    int          gap;        // idle cycles with rxdv low after the frame
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxd = 8'h00;
  logic        rxdv = 1'b0;
  logic [47:0] pc_mac;
  logic [31:0] pc_ip;
  logic [15:0] identify;
  logic [15:0] seq_num;
  logic        icmp_rx_done;
  logic        icmp_rx_err;

  int n_checks = 0;
  int n_errors = 0;
  int done_total = 0;
  int err_total = 0;
  int both_total = 0;
  int exp_done_total = 0;
  int exp_err_total = 0;
  int snap_d;
  int snap_e;

  logic [47:0] exp_mac = '0;
  logic [31:0] exp_ip = '0;
  logic [15:0] exp_id = '0;
  logic [15:0] exp_seq = '0;

  logic [7:0] body[$];
  logic [7:0] fb[$];
  vec_t       vecs[$];
  vec_t       v;

  icmp_rx dut (
    .clk           (clk),
    .rst           (rst),
    .gmii_eth_rxd  (rxd),
    .gmii_eth_rxdv (rxdv),
    .pc_mac        (pc_mac),
    .pc_ip         (pc_ip),
    .identify      (identify),
    .seq_num       (seq_num),
    .icmp_rx_done  (icmp_rx_done),
    .icmp_rx_err   (icmp_rx_err)
  );

  always #5 clk = ~clk;

  // Pulse totals, one count per high cycle.
  always @(negedge clk) begin
    if (icmp_rx_done) done_total++;
    if (icmp_rx_err) err_total++;
    if (icmp_rx_done && icmp_rx_err) both_total++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t base(input string name, input logic [15:0] seq);
    vec_t r;
    r.name = name;           r.pre_len = 7;
    r.dst_mac = 48'h00_11_22_33_44_55;
    r.src_mac = 48'h0A_0B_0C_0D_0E_0F;
    r.ethertype = 16'h0800;  r.ver_ihl = 8'h45;  r.proto = 8'h01;
    r.src_ip = 32'hC0A8_0164; r.dst_ip = 32'hC0A8_010A;
    r.icmp_type = 8'h08;     r.id = 16'h0001;   r.seq = seq;
    r.pay_len = 32;          r.fcs_flip = 1'b0; r.trunc = 0; r.gap = 12;
    r.exp_done = 1'b1;       r.exp_err = 1'b0;
    return r;
  endfunction

  // Build preamble + frame + Ethernet FCS into fb.
  task automatic build(input vec_t f);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [15:0] tot_len;
    int n;
    body.delete();
    fb.delete();
    tot_len = 16'(28 + f.pay_len);
    for (int k = 5; k >= 0; k--) body.push_back(f.dst_mac[8*k +: 8]);
    for (int k = 5; k >= 0; k--) body.push_back(f.src_mac[8*k +: 8]);
    body.push_back(f.ethertype[15:8]); body.push_back(f.ethertype[7:0]);
    body.push_back(f.ver_ihl); body.push_back(8'h00);
    body.push_back(tot_len[15:8]); body.push_back(tot_len[7:0]);
    body.push_back(8'h00); body.push_back(8'h00); body.push_back(8'h40); body.push_back(8'h00);
    body.push_back(8'h40); body.push_back(f.proto); body.push_back(8'h00); body.push_back(8'h00);
    for (int k = 3; k >= 0; k--) body.push_back(f.src_ip[8*k +: 8]);
    for (int k = 3; k >= 0; k--) body.push_back(f.dst_ip[8*k +: 8]);
    body.push_back(f.icmp_type); body.push_back(8'h00); body.push_back(8'h00); body.push_back(8'h00);
    body.push_back(f.id[15:8]); body.push_back(f.id[7:0]);
    body.push_back(f.seq[15:8]); body.push_back(f.seq[7:0]);
    for (int k = 0; k < f.pay_len; k++) body.push_back(8'(k));
    crc = 32'hFFFF_FFFF;
    foreach (body[i]) begin
      crc = crc ^ {24'h0, body[i]};
      for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) body.push_back(fcs[8*k +: 8]);
    if (f.fcs_flip) body[body.size() - 4] = body[body.size() - 4] ^ 8'h01;
    n = (f.trunc > 0) ? f.trunc : body.size();
    for (int k = 0; k < f.pre_len; k++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    for (int k = 0; k < n; k++) fb.push_back(body[k]);
  endtask

  // Drive one frame, then check the pulse and outputs one cycle after the
  // edge that samples rxdv low.
  task automatic send(input vec_t f);
    build(f);
    foreach (fb[i]) begin
      @(negedge clk);
      rxdv = 1'b1;
      rxd  = fb[i];
    end
    @(negedge clk);
    rxdv = 1'b0;
    rxd  = 8'h00;
    @(posedge clk);
    #1;
    if (f.exp_done) begin
      exp_mac = f.src_mac; exp_ip = f.src_ip; exp_id = f.id; exp_seq = f.seq;
    end
    exp_done_total += int'(f.exp_done);
    exp_err_total  += int'(f.exp_err);
    check({f.name, " done"}, icmp_rx_done, f.exp_done);
    check({f.name, " err"}, icmp_rx_err, f.exp_err);
    check({f.name, " pc_mac"}, pc_mac, exp_mac);
    check({f.name, " pc_ip"}, pc_ip, exp_ip);
    check({f.name, " identify"}, identify, exp_id);
    check({f.name, " sequence"}, seq_num, exp_seq);
    repeat (f.gap - 1) @(negedge clk);
  endtask

  initial begin
    // Stimulus table.
    v = base("valid", 16'h0025);                                     vecs.push_back(v);
    v = base("dst_ip_11", 16'h0099); v.dst_ip = 32'hC0A8_010B; v.exp_done = 0; vecs.push_back(v);
    v = base("type_reply", 16'h0098); v.icmp_type = 8'h00; v.exp_done = 0;    vecs.push_back(v);
    v = base("dst_mac_other", 16'h0097); v.dst_mac = 48'h00_11_22_33_44_56; v.exp_done = 0; vecs.push_back(v);
    v = base("ethertype_arp", 16'h0096); v.ethertype = 16'h0806; v.exp_done = 0; vecs.push_back(v);
    v = base("ihl_6", 16'h0095); v.ver_ihl = 8'h46; v.exp_done = 0;           vecs.push_back(v);
    v = base("proto_tcp", 16'h0094); v.proto = 8'h06; v.exp_done = 0;         vecs.push_back(v);
    v = base("fcs_flip", 16'h0026); v.src_mac = 48'h0A_0B_0C_0D_0E_10; v.fcs_flip = 1;
    v.exp_done = !CRC_EN; v.exp_err = CRC_EN;                                 vecs.push_back(v);
    v = base("trunc_eth", 16'h0093); v.trunc = 5; v.exp_done = 0; v.exp_err = 1;  vecs.push_back(v);
    v = base("trunc_ip10", 16'h0092); v.trunc = 25; v.exp_done = 0; v.exp_err = 1; vecs.push_back(v);
    v = base("trunc_icmp", 16'h0091); v.trunc = 38; v.exp_done = 0; v.exp_err = 1; vecs.push_back(v);
    v = base("short_45", 16'h0090); v.trunc = 45; v.exp_done = 0; v.exp_err = 1;   vecs.push_back(v);
    v = base("min_46", 16'h0030); v.pay_len = 0; v.src_ip = 32'hC0A8_0165;   vecs.push_back(v);
    v = base("pre_1", 16'h0031); v.pre_len = 1; v.id = 16'hBEEF;             vecs.push_back(v);
    v = base("pre_8", 16'h0089); v.pre_len = 8; v.exp_done = 0;              vecs.push_back(v);
    v = base("no_pre", 16'h0088); v.pre_len = 0; v.exp_done = 0;             vecs.push_back(v);
    v = base("seq_1", 16'h0001);                                             vecs.push_back(v);
    v = base("seq_2", 16'h0002); v.src_mac = 48'h02_00_00_00_00_02;          vecs.push_back(v);
    v = base("b2b_a", 16'h0003); v.gap = 1;                                  vecs.push_back(v);
    v = base("b2b_b", 16'h0004); v.id = 16'h1234; v.src_ip = 32'hC0A8_01FE; vecs.push_back(v);
    v = base("max_1522", 16'h0040); v.pay_len = 1476;                        vecs.push_back(v);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset pc_mac", pc_mac, 48'h0);
    check("reset pc_ip", pc_ip, 32'h0);
    check("reset identify", identify, 16'h0);
    check("reset sequence", seq_num, 16'h0);
    check("reset done", icmp_rx_done, 1'b0);
    check("reset err", icmp_rx_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) send(vecs[i]);

    // Oversize: 1523 bytes after SFD -> one err pulse mid-frame, no done.
    snap_d = done_total;
    snap_e = err_total;
    v = base("oversize", 16'h0050); v.pay_len = 1477; v.exp_done = 0;
    send(v);
    repeat (3) @(negedge clk);
    exp_err_total += 1;
    check("oversize err pulses", 64'(err_total - snap_e), 64'd1);
    check("oversize done pulses", 64'(done_total - snap_d), 64'd0);

    // Reset asserted during ETH_HDR while rxdv stays high to frame end.
    snap_d = done_total;
    snap_e = err_total;
    build(base("rst_mid", 16'h0077));
    foreach (fb[i]) begin
      @(negedge clk);
      rxdv = 1'b1;
      rxd  = fb[i];
      if (i == 13) rst = 1'b1;
      if (i == 15) rst = 1'b0;
      if (i == 15) begin
        check("rst_mid pc_mac", pc_mac, 48'h0);
        check("rst_mid pc_ip", pc_ip, 32'h0);
        check("rst_mid identify", identify, 16'h0);
        check("rst_mid sequence", seq_num, 16'h0);
      end
    end
    @(negedge clk);
    rxdv = 1'b0;
    repeat (6) @(negedge clk);
    exp_mac = '0; exp_ip = '0; exp_id = '0; exp_seq = '0;
    check("rst_mid done pulses", 64'(done_total - snap_d), 64'd0);
    check("rst_mid err pulses", 64'(err_total - snap_e), 64'd0);
    check("rst_mid pc_mac after", pc_mac, 48'h0);
    send(base("after_rst", 16'h0078));

    repeat (4) @(negedge clk);
    check("total done pulses", 64'(done_total), 64'(exp_done_total));
    check("total err pulses", 64'(err_total), 64'(exp_err_total));
    check("done and err together", 64'(both_total), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
